// File: rtl/bus_dest_regs_if.sv
// Bus-side signal bundle for bus_dest_regs: the bus value and destination controls in, every stored register out.
// BAout exists only when BUS_DEST_R0_BA_EN is defined.
interface bus_dest_regs_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] BusMuxOut;
   logic [4:0]       dest_sel;
   logic             load;
   logic             IncPC;
`ifdef BUS_DEST_R0_BA_EN
   logic             BAout;
`endif
   logic [WIDTH-1:0] BusMuxIn_R0,  BusMuxIn_R1,  BusMuxIn_R2,  BusMuxIn_R3;
   logic [WIDTH-1:0] BusMuxIn_R4,  BusMuxIn_R5,  BusMuxIn_R6,  BusMuxIn_R7;
   logic [WIDTH-1:0] BusMuxIn_R8,  BusMuxIn_R9,  BusMuxIn_R10, BusMuxIn_R11;
   logic [WIDTH-1:0] BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15;
   logic [WIDTH-1:0] BusMuxIn_HI,  BusMuxIn_LO,  BusMuxIn_PC;
   logic             illegal_dest;

   modport master (
      output BusMuxOut, dest_sel, load, IncPC,
`ifdef BUS_DEST_R0_BA_EN
      output BAout,
`endif
      input  BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3,
             BusMuxIn_R4, BusMuxIn_R5, BusMuxIn_R6, BusMuxIn_R7,
             BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11,
             BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15,
             BusMuxIn_HI, BusMuxIn_LO, BusMuxIn_PC, illegal_dest
   );

   modport slave (
      input  BusMuxOut, dest_sel, load, IncPC,
`ifdef BUS_DEST_R0_BA_EN
      input  BAout,
`endif
      output BusMuxIn_R0, BusMuxIn_R1, BusMuxIn_R2, BusMuxIn_R3,
             BusMuxIn_R4, BusMuxIn_R5, BusMuxIn_R6, BusMuxIn_R7,
             BusMuxIn_R8, BusMuxIn_R9, BusMuxIn_R10, BusMuxIn_R11,
             BusMuxIn_R12, BusMuxIn_R13, BusMuxIn_R14, BusMuxIn_R15,
             BusMuxIn_HI, BusMuxIn_LO, BusMuxIn_PC, illegal_dest
   );
endinterface

// File: rtl/bus_dest_regs.sv
// Load side of the datapath bus: R0-R15, HI, LO and PC, each driven back out as a bus mux source.
// Optional BUS_DEST_R0_BA_EN adds BAout, which forces the R0 source to zero without touching stored R0.
module bus_dest_regs #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] PC_RESET = '0,
   parameter logic [WIDTH-1:0] PC_STEP  = 1
) (
   input logic            clock,
   input logic            clear,
   bus_dest_regs_if.slave bus
);
   localparam logic [4:0] SEL_HI = 5'd16;
   localparam logic [4:0] SEL_LO = 5'd17;
   localparam logic [4:0] SEL_PC = 5'd20;

   logic [WIDTH-1:0] gpr [16];
   logic [WIDTH-1:0] hi_reg, lo_reg, pc_reg;
   logic             illegal_reg;
   logic             wr_gpr, wr_hi, wr_lo, wr_pc, bad_dest;

   // Codes 0-15 map onto the general registers; anything not owned here raises the sticky flag.
   always_comb begin
      wr_gpr   = bus.load && !bus.dest_sel[4];
      wr_hi    = bus.load && (bus.dest_sel == SEL_HI);
      wr_lo    = bus.load && (bus.dest_sel == SEL_LO);
      wr_pc    = bus.load && (bus.dest_sel == SEL_PC);
      bad_dest = bus.load && !(wr_gpr || wr_hi || wr_lo || wr_pc);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         for (int i = 0; i < 16; i++) gpr[i] <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         pc_reg      <= PC_RESET;
         illegal_reg <= 1'b0;
      end else begin
         if (wr_gpr) gpr[bus.dest_sel[3:0]] <= bus.BusMuxOut;
         if (wr_hi)  hi_reg <= bus.BusMuxOut;
         if (wr_lo)  lo_reg <= bus.BusMuxOut;
         // A bus load into PC takes priority; the increment for that cycle is dropped.
         if (wr_pc)          pc_reg <= bus.BusMuxOut;
         else if (bus.IncPC) pc_reg <= pc_reg + PC_STEP;
         if (bad_dest) illegal_reg <= 1'b1;
      end
   end

`ifdef BUS_DEST_R0_BA_EN
   assign bus.BusMuxIn_R0 = bus.BAout ? '0 : gpr[0];
`else
   assign bus.BusMuxIn_R0 = gpr[0];
`endif
   assign bus.BusMuxIn_R1  = gpr[1];
   assign bus.BusMuxIn_R2  = gpr[2];
   assign bus.BusMuxIn_R3  = gpr[3];
   assign bus.BusMuxIn_R4  = gpr[4];
   assign bus.BusMuxIn_R5  = gpr[5];
   assign bus.BusMuxIn_R6  = gpr[6];
   assign bus.BusMuxIn_R7  = gpr[7];
   assign bus.BusMuxIn_R8  = gpr[8];
   assign bus.BusMuxIn_R9  = gpr[9];
   assign bus.BusMuxIn_R10 = gpr[10];
   assign bus.BusMuxIn_R11 = gpr[11];
   assign bus.BusMuxIn_R12 = gpr[12];
   assign bus.BusMuxIn_R13 = gpr[13];
   assign bus.BusMuxIn_R14 = gpr[14];
   assign bus.BusMuxIn_R15 = gpr[15];
   assign bus.BusMuxIn_HI  = hi_reg;
   assign bus.BusMuxIn_LO  = lo_reg;
   assign bus.BusMuxIn_PC  = pc_reg;
   assign bus.illegal_dest = illegal_reg;
endmodule

// File: tb/tb_bus_dest_regs.sv
// Directed bench for bus_dest_regs: a vector table for single-cycle loads plus hand sequences for
// latency, PC wrap/priority, the sticky illegal flag, clear priority and (if BUS_DEST_R0_BA_EN) BAout.
module tb_bus_dest_regs;
   localparam int WIDTH = 32;

   typedef struct {
      logic        ld;
      logic [4:0]  sel;
      logic [31:0] data;
      logic        inc;
      logic [4:0]  chk;
      logic [31:0] expv;
      logic        exp_ill;
   } vec_t;

   logic clock = 1'b0;
   logic clear;
   int   vectors = 0;
   int   miscompares = 0;
   vec_t tbl [15];

   always #5 clock = ~clock;

   bus_dest_regs_if #(.WIDTH(WIDTH)) bus ();

   bus_dest_regs #(.WIDTH(WIDTH), .PC_RESET(32'h0), .PC_STEP(32'h1)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.slave)
   );

   function automatic logic [31:0] out_of(input logic [4:0] sel);
      case (sel)
         5'd0:    return bus.BusMuxIn_R0;
         5'd1:    return bus.BusMuxIn_R1;
         5'd2:    return bus.BusMuxIn_R2;
         5'd3:    return bus.BusMuxIn_R3;
         5'd4:    return bus.BusMuxIn_R4;
         5'd5:    return bus.BusMuxIn_R5;
         5'd6:    return bus.BusMuxIn_R6;
         5'd7:    return bus.BusMuxIn_R7;
         5'd8:    return bus.BusMuxIn_R8;
         5'd9:    return bus.BusMuxIn_R9;
         5'd10:   return bus.BusMuxIn_R10;
         5'd11:   return bus.BusMuxIn_R11;
         5'd12:   return bus.BusMuxIn_R12;
         5'd13:   return bus.BusMuxIn_R13;
         5'd14:   return bus.BusMuxIn_R14;
         5'd15:   return bus.BusMuxIn_R15;
         5'd16:   return bus.BusMuxIn_HI;
         5'd17:   return bus.BusMuxIn_LO;
         default: return bus.BusMuxIn_PC;
      endcase
   endfunction

   task automatic drive(input logic ld, input logic [4:0] sel, input logic [31:0] data, input logic inc);
      bus.load      = ld;
      bus.dest_sel  = sel;
      bus.BusMuxOut = data;
      bus.IncPC     = inc;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   initial begin
      drive(1'b0, 5'd0, 32'h0, 1'b0);
`ifdef BUS_DEST_R0_BA_EN
      bus.BAout = 1'b0;
`endif
      clear = 1'b1;
      tick();
      clear = 1'b0;

      for (int s = 0; s < 21; s++) begin
         if (s < 18 || s == 20) check($sformatf("reset_sel%0d", s), out_of(5'(s)), 32'h0);
      end
      check("reset_illegal", {31'b0, bus.illegal_dest}, 32'h0);

      // sel/data/inc applied for one cycle, then register chk is compared after the edge
      tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
      tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd4,  32'h0,        1'b0};
      tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd6,  32'h0,        1'b0};
      tbl[3]  = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h55,       1'b0};
      tbl[4]  = '{1'b1, 5'd15, 32'hA5A5A5A5, 1'b0, 5'd15, 32'hA5A5A5A5, 1'b0};
      tbl[5]  = '{1'b1, 5'd17, 32'h12345678, 1'b0, 5'd17, 32'h12345678, 1'b0};
      tbl[6]  = '{1'b1, 5'd16, 32'h7,        1'b1, 5'd16, 32'h7,        1'b0};
      tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd20, 32'h1,        1'b0};
      tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 32'h2,        1'b0};
      tbl[9]  = '{1'b1, 5'd20, 32'h100,      1'b1, 5'd20, 32'h100,      1'b0};
      tbl[10] = '{1'b1, 5'd5,  32'h1,        1'b0, 5'd5,  32'h1,        1'b0};
      tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd15, 32'hA5A5A5A5, 1'b0};
      tbl[12] = '{1'b1, 5'd18, 32'hFFFF,     1'b0, 5'd17, 32'h12345678, 1'b1};
      tbl[13] = '{1'b0, 5'd19, 32'h0,        1'b0, 5'd5,  32'h1,        1'b1};
      tbl[14] = '{1'b1, 5'd21, 32'h0,        1'b0, 5'd20, 32'h100,      1'b1};

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].ld, tbl[i].sel, tbl[i].data, tbl[i].inc);
         tick();
         check($sformatf("vec%0d_data", i), out_of(tbl[i].chk), tbl[i].expv);
         check($sformatf("vec%0d_illegal", i), {31'b0, bus.illegal_dest}, {31'b0, tbl[i].exp_ill});
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0);

      // New value appears only after the edge; no bypass in the load cycle.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
      #1;
      check("nobypass_old", bus.BusMuxIn_R5, 32'h0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      check("nobypass_new", bus.BusMuxIn_R5, 32'hDEADBEEF);
      check("neighbour_r4", bus.BusMuxIn_R4, 32'h0);
      check("neighbour_r6", bus.BusMuxIn_R6, 32'h0);

      drive(1'b1, 5'd20, 32'hFFFFFFFF, 1'b0);
      tick();
      check("pc_load_max", bus.BusMuxIn_PC, 32'hFFFFFFFF);
      drive(1'b0, 5'd0, 32'h0, 1'b1);
      tick();
      check("pc_wrap", bus.BusMuxIn_PC, 32'h0);
      drive(1'b1, 5'd20, 32'h100, 1'b1);
      tick();
      check("pc_load_beats_inc", bus.BusMuxIn_PC, 32'h100);

      drive(1'b1, 5'd20, 32'h3, 1'b0);
      tick();
      drive(1'b1, 5'd16, 32'h7, 1'b1);
      tick();
      check("hi_with_inc", bus.BusMuxIn_HI, 32'h7);
      check("pc_with_hi", bus.BusMuxIn_PC, 32'h4);

      drive(1'b1, 5'd19, 32'hBAD, 1'b0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      check("illegal_set", {31'b0, bus.illegal_dest}, 32'h1);
      check("illegal_no_write_r5", bus.BusMuxIn_R5, 32'hDEADBEEF);
      check("illegal_no_write_hi", bus.BusMuxIn_HI, 32'h7);
      repeat (10) tick();
      check("illegal_sticky", {31'b0, bus.illegal_dest}, 32'h1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("illegal_cleared", {31'b0, bus.illegal_dest}, 32'h0);

      drive(1'b1, 5'd2, 32'h77, 1'b0);
      tick();
      check("r2_loaded", bus.BusMuxIn_R2, 32'h77);
      clear = 1'b1;
      drive(1'b1, 5'd2, 32'h9, 1'b1);
      tick();
      clear = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      check("clear_beats_load", bus.BusMuxIn_R2, 32'h0);
      check("clear_beats_inc", bus.BusMuxIn_PC, 32'h0);

`ifdef BUS_DEST_R0_BA_EN
      drive(1'b1, 5'd0, 32'h55, 1'b0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      bus.BAout = 1'b1;
      #1;
      check("ba_forces_zero", bus.BusMuxIn_R0, 32'h0);
      bus.BAout = 1'b0;
      #1;
      check("ba_released", bus.BusMuxIn_R0, 32'h55);
      bus.BAout = 1'b1;
      drive(1'b1, 5'd0, 32'h66, 1'b0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      check("ba_load_masked", bus.BusMuxIn_R0, 32'h0);
      bus.BAout = 1'b0;
      #1;
      check("ba_load_stored", bus.BusMuxIn_R0, 32'h66);
      clear = 1'b1;
      drive(1'b1, 5'd0, 32'h9, 1'b0);
      tick();
      clear = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0);
      check("ba_clear_beats_load", bus.BusMuxIn_R0, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
